// File: rtl/pps_qualifier.sv
// PPS qualifier: synchronises a raw receiver PPS, measures edge-to-edge intervals in
// AC-derived ticks and only forwards pulses once the interval has been stable.
module pps_qualifier #(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned TOL      = 1,
    parameter int unsigned HOLDOVER = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ac50_sel,
    input  logic       pps_raw,
    output logic       pps_out,
    output logic       locked,
    output logic       pps_err,
    output logic [6:0] interval,
    output logic [1:0] state
);

    localparam int unsigned IW = 7;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        ACQ    = 2'd1,
        LOCK   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        st_q, st_d;
    logic          s1, s2, ac_q;
    logic [IW-1:0] iv_cnt, iv_d, interval_d;
    logic [2:0]    good_cnt, good_d, miss_cnt, miss_d, miss_inc;
    logic          out_d, err_d, locked_d;
    logic          pps_edge, good, timeout;
    logic [IW-1:0] nom, lo, hi, meas;

    assign pps_edge = s1 & ~s2;
    assign nom      = ac_q ? IW'(50) : IW'(60);
    assign hi       = nom + IW'(TOL);
    assign lo       = nom - IW'(TOL);
    assign meas     = iv_cnt + IW'(1);
    assign good     = (meas >= lo) && (meas <= hi);
    assign timeout  = !pps_edge && (iv_cnt == hi);
    assign miss_inc = miss_cnt + 3'd1;
    assign state    = st_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            ac_q     <= ac50_sel;
            iv_cnt   <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
            interval <= '0;
            st_q     <= UNLOCK;
            pps_out  <= 1'b0;
            pps_err  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            s1       <= pps_raw;
            s2       <= s1;
            ac_q     <= ac50_sel;
            iv_cnt   <= iv_d;
            good_cnt <= good_d;
            miss_cnt <= miss_d;
            interval <= interval_d;
            st_q     <= st_d;
            pps_out  <= out_d;
            pps_err  <= err_d;
            locked   <= locked_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        st_d       = st_q;
        good_d     = good_cnt;
        miss_d     = miss_cnt;
        out_d      = 1'b0;
        err_d      = 1'b0;
        interval_d = pps_edge ? meas : interval;
        if (pps_edge)
            iv_d = '0;
        else if (iv_cnt == IW'(126))
            iv_d = iv_cnt;
        else
            iv_d = iv_cnt + IW'(1);

        if (ac50_sel != ac_q) begin
            st_d   = UNLOCK;
            good_d = '0;
            miss_d = '0;
        end else begin
            unique case (st_q)
                UNLOCK: begin
                    if (pps_edge) begin
                        st_d   = ACQ;
                        good_d = '0;
                    end
                end
                ACQ: begin
                    if (pps_edge) begin
                        if (good) begin
                            good_d = good_cnt + 3'd1;
                            if (good_cnt + 3'd1 == 3'(LOCK_CNT)) begin
                                st_d   = LOCK;
                                miss_d = '0;
                                out_d  = 1'b1;
                            end
                        end else begin
                            good_d = '0;
                            err_d  = 1'b1;
                        end
                    end else if (timeout) begin
                        st_d  = UNLOCK;
                        err_d = 1'b1;
                    end
                end
                LOCK, HOLD: begin
                    if (pps_edge) begin
                        miss_d = '0;
                        if (good) begin
                            st_d  = LOCK;
                            out_d = 1'b1;
                        end else begin
                            st_d   = ACQ;
                            good_d = '0;
                            err_d  = 1'b1;
                        end
                    end else if (timeout) begin
                        // Re-centre the counter on where the missed edge should have been
                        iv_d   = IW'(TOL + 1);
                        err_d  = 1'b1;
                        miss_d = miss_inc;
                        if (miss_inc >= 3'(HOLDOVER)) begin
                            st_d   = UNLOCK;
                            miss_d = '0;
                        end else begin
                            st_d = HOLD;
                        end
                    end
                end
                default: st_d = UNLOCK;
            endcase
        end

        locked_d = (st_d == LOCK) || (st_d == HOLD);
    end

endmodule
